wb_stage: RTL

- Writeback stage of the five-stage RV32I pipeline; sits between the MEM stage and the register file.
- Registers retiring instructions and selects the writeback source: ALU result, aligned/extended load data or PC+4.
- Waits on the data-memory read response for loads, then drives the register file write port (reg_wen, wb_rd, wb_data).
- Outputs are registered on posedge and stable for a full cycle, so the register file's negedge write samples settled values.

---
 rtl/riscv_pkg.sv | 21 ++
 rtl/wb_stage_if.sv | 25 ++
 rtl/wb_stage_load_align.sv | 24 ++
 rtl/wb_stage.sv | 124 ++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline types: writeback source select, load funct3 codes, WB FSM states.
package riscv_pkg;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_LOAD = 2'b01,
        WB_PC4  = 2'b10
    } wb_sel_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic {
        IDLE      = 1'b0,
        LOAD_WAIT = 1'b1
    } wb_state_e;

endpackage

// File: rtl/wb_stage_if.sv
// MEM -> WB handshake bus; master is the MEM stage, slave is the writeback stage.
interface wb_stage_if #(
    parameter int unsigned XLEN = 32
);
    logic            mem_valid;
    logic            mem_ready;
    logic            mem_reg_wen;
    logic [4:0]      mem_rd;
    logic [1:0]      mem_wb_sel;
    logic [2:0]      mem_funct3;
    logic [XLEN-1:0] mem_alu_result;
    logic [XLEN-1:0] mem_pc_plus4;

    modport master (
        output mem_valid, mem_reg_wen, mem_rd, mem_wb_sel, mem_funct3,
               mem_alu_result, mem_pc_plus4,
        input  mem_ready
    );

    modport slave (
        input  mem_valid, mem_reg_wen, mem_rd, mem_wb_sel, mem_funct3,
               mem_alu_result, mem_pc_plus4,
        output mem_ready
    );
endinterface

// File: rtl/wb_stage_load_align.sv
// Load data alignment: shifts the word-aligned read data by the byte offset and sign/zero-extends.
module load_align
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [2:0]      funct3,
    input  logic [1:0]      byte_off,
    output logic [XLEN-1:0] data
);
    logic [XLEN-1:0] shifted;

    always_comb begin
        shifted = rdata >> {byte_off, 3'b000};
        case (funct3)
            F3_LB:   data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            F3_LH:   data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            F3_LBU:  data = {{(XLEN-8){1'b0}}, shifted[7:0]};
            F3_LHU:  data = {{(XLEN-16){1'b0}}, shifted[15:0]};
            default: data = shifted;
        endcase
    end
endmodule

// File: rtl/wb_stage.sv
// RV32I writeback stage: registers retiring instructions and drives the register file write port.
// Optional retire counter enabled by defining WB_RETIRE_CNT_EN.
module wb_stage
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    wb_stage_if.slave        mem,
    input  logic             dmem_rvalid,
    input  logic [XLEN-1:0]  dmem_rdata,
    output logic             reg_wen,
    output logic [4:0]       wb_rd,
    output logic [XLEN-1:0]  wb_data
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [CNT_W-1:0] retire_cnt
`endif
);
    wb_state_e       state_q, state_d;
    logic            reg_wen_q, reg_wen_d;
    logic [4:0]      wb_rd_q, wb_rd_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;
    logic            ld_wen_q, ld_wen_d;
    logic [4:0]      ld_rd_q, ld_rd_d;
    logic [2:0]      ld_f3_q, ld_f3_d;
    logic [1:0]      ld_off_q, ld_off_d;
    logic [XLEN-1:0] load_data;

    load_align #(.XLEN(XLEN)) u_load_align (
        .rdata    (dmem_rdata),
        .funct3   (ld_f3_q),
        .byte_off (ld_off_q),
        .data     (load_data)
    );

    assign mem.mem_ready = (state_q == IDLE);

    always_comb begin
        state_d   = state_q;
        reg_wen_d = 1'b0;
        wb_rd_d   = wb_rd_q;
        wb_data_d = wb_data_q;
        ld_wen_d  = ld_wen_q;
        ld_rd_d   = ld_rd_q;
        ld_f3_d   = ld_f3_q;
        ld_off_d  = ld_off_q;
        case (state_q)
            IDLE: begin
                if (mem.mem_valid) begin
                    if (mem.mem_wb_sel == WB_LOAD) begin
                        ld_wen_d = mem.mem_reg_wen;
                        ld_rd_d  = mem.mem_rd;
                        ld_f3_d  = mem.mem_funct3;
                        ld_off_d = mem.mem_alu_result[1:0];
                        state_d  = LOAD_WAIT;
                    end else begin
                        reg_wen_d = mem.mem_reg_wen && (mem.mem_rd != 5'd0);
                        wb_rd_d   = mem.mem_rd;
                        // reserved select 11 falls through to the ALU result
                        wb_data_d = (mem.mem_wb_sel == WB_PC4) ? mem.mem_pc_plus4
                                                               : mem.mem_alu_result;
                    end
                end
            end
            LOAD_WAIT: begin
                if (dmem_rvalid) begin
                    reg_wen_d = ld_wen_q && (ld_rd_q != 5'd0);
                    wb_rd_d   = ld_rd_q;
                    wb_data_d = load_data;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            reg_wen_q <= 1'b0;
            wb_rd_q   <= '0;
            wb_data_q <= '0;
            ld_wen_q  <= 1'b0;
            ld_rd_q   <= '0;
            ld_f3_q   <= '0;
            ld_off_q  <= '0;
        end else begin
            state_q   <= state_d;
            reg_wen_q <= reg_wen_d;
            wb_rd_q   <= wb_rd_d;
            wb_data_q <= wb_data_d;
            ld_wen_q  <= ld_wen_d;
            ld_rd_q   <= ld_rd_d;
            ld_f3_q   <= ld_f3_d;
            ld_off_q  <= ld_off_d;
        end
    end

    assign reg_wen = reg_wen_q;
    assign wb_rd   = wb_rd_q;
    assign wb_data = wb_data_q;

`ifdef WB_RETIRE_CNT_EN
    logic             retire;
    logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;

    // counts every completion, including x0 writes and non-writing ops
    always_comb begin
        retire = ((state_q == IDLE) && mem.mem_valid && (mem.mem_wb_sel != WB_LOAD)) ||
                 ((state_q == LOAD_WAIT) && dmem_rvalid);
        retire_cnt_d = retire_cnt_q + (retire ? {{(CNT_W-1){1'b0}}, 1'b1} : '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) retire_cnt_q <= '0;
        else     retire_cnt_q <= retire_cnt_d;
    end

    assign retire_cnt = retire_cnt_q;
`endif
endmodule
